tube_r3_dma_ctrl: RTL and testbench
===================================

Name: tube_r3_dma_ctrl

Overview:
Parasite-side sequencer that moves a block of bytes between parasite memory and Tube register 3 (p_addr=3'b101). It runs without CPU involvement and is paced by the Tube's active-low NMI output. It sits between the Tube ULA parasite bus (p_addr/p_cs_b/p_rd_b/p_wr_b/p_data) and a simple req/ack memory port. It replaces the CPU's NMI handler for bulk file and language transfers, in both 1-byte and 2-byte (V flag) R3 modes.

Parameters:
ADDR_W, 16, memory address width
CNT_W, 16, transfer byte-count width
STROBE_CYC, 2, p_clk cycles p_rd_b/p_wr_b held low (>=1)
SYNC_STAGES, 2, synchroniser depth on p_nmi_b

Ports:
p_clk  input  1  parasite clock
p_rst_b  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse, latches cfg and begins transfer
dir  input  1  1 = host->parasite (read R3), 0 = parasite->host (write R3)
two_byte  input  1  service 2 bytes per NMI (matches Tube V flag)
base_addr  input  ADDR_W  first memory address
byte_count  input  CNT_W  bytes to move
abort  input  1  request early termination
p_nmi_b  input  1  Tube NMI, asynchronous, active low
p_addr  output  3  Tube register select
p_cs_b  output  1  Tube chip select
p_rd_b  output  1  Tube read strobe
p_wr_b  output  1  Tube write strobe
p_data_out  output  8  write data to Tube
p_data_oe  output  1  drive p_data_out onto the bus
p_data_in  input  8  read data from Tube
mem_req  output  1  memory request, held until mem_ack
mem_we  output  1  1 = memory write
mem_addr  output  ADDR_W  memory address
mem_wdata  output  8  memory write data
mem_rdata  input  8  memory read data, valid with mem_ack
mem_ack  input  1  memory completion, one cycle
busy  output  1  transfer in progress
done  output  1  one-cycle pulse at end of transfer
aborted  output  1  sticky; last transfer ended by abort; cleared on start
remaining  output  CNT_W  bytes still to move

Behaviour:
- Reset values: p_cs_b/p_rd_b/p_wr_b=1, p_addr=3'b101, p_data_oe=0, mem_req=0, busy=0, done=0, aborted=0, remaining=0, state IDLE. Reset is asynchronous: strobes go high immediately, including mid-strobe.
- p_nmi_b passes through a SYNC_STAGES flop synchroniser; nmi = !synchronised value.
- States: IDLE, ARM, WAIT_NMI, MEM_RD, BUS_SETUP, BUS_STROBE, BUS_HOLD, MEM_WR, NEXT, GUARD, FINISH.
- IDLE: on start, latch cfg, set addr=base_addr, remaining=byte_count, clear aborted. If byte_count==0, go to FINISH (no bus cycles). Otherwise go to WAIT_NMI. start is ignored while busy.
- WAIT_NMI: when nmi is high, set burst=(two_byte && remaining>=2)?2:1. Dir 0 goes to MEM_RD; dir 1 goes to BUS_SETUP.
- MEM_RD: mem_req=1, mem_we=0. On mem_ack, capture mem_rdata into p_data_out, then go to BUS_SETUP.
- BUS_SETUP (1 cycle): p_cs_b=0. p_data_oe=1 if dir=0.
- BUS_STROBE (STROBE_CYC cycles): p_rd_b=0 (dir 1) or p_wr_b=0 (dir 0). For dir 1, p_data_in is captured on the last strobe cycle.
- BUS_HOLD (1 cycle): strobes high, p_cs_b=0, oe held. The Tube latches write data on the rising edge of p_wr_b here.
- Then dir 1 goes to MEM_WR; dir 0 goes to NEXT.
- MEM_WR: mem_req=1, mem_we=1, mem_wdata=captured byte. Wait for mem_ack, then go to NEXT.
- NEXT: addr+1 (wraps mod 2^ADDR_W), remaining-1, burst-1.
  - If remaining becomes 0, go to FINISH.
  - Else if burst>0, go to MEM_RD or BUS_SETUP without waiting for NMI.
  - Else go to GUARD.
- GUARD: SYNC_STAGES+1 cycles, nmi ignored. This prevents a stale synchronised NMI from retriggering. Then go to WAIT_NMI.
- FINISH: done=1 for one cycle, busy=0, return to IDLE.
- busy=1 in every state except IDLE and FINISH.
- abort: sampled in every state.
  - In WAIT_NMI or GUARD: go straight to FINISH with aborted=1.
  - In MEM_*/BUS_*: finish the current byte through NEXT (a strobe is never truncated), then go to FINISH with aborted=1.
  - abort during IDLE is ignored.
- A single NMI never triggers more than one burst. Memory latency is unbounded; the Tube bus stays idle (cs_b=1) while mem_req is pending.

Decomposition:
- Package tube_pkg: state enum, R3 address constant 3'b101, direction encodings.
- One sub-module, tube_pbus_cycle: the SETUP/STROBE/HOLD strobe generator with start/done handshake and STROBE_CYC parameter. It is reusable for other parasite-side Tube accesses.

Test Plan:
- dir=1, count=3, base=16'h0400, 1-byte mode, NMI asserted three times with data A1,A2,A3 -> exactly three p_rd_b pulses of 2 cycles; memory 0400..0402=A1,A2,A3; one done pulse; remaining=0.
- dir=0, two_byte=1, count=5, NMI held low -> bursts of 2,2,1; five p_wr_b rising edges with p_data_oe=1; GUARD gap between bursts; no extra strobes.
- count=0 start -> done pulse 1 cycle later; no p_cs_b activity; busy stays 0.
- abort raised mid BUS_STROBE of byte 2/10 -> strobe completes full width; remaining=8; aborted=1; done pulses; next start clears aborted.
- mem_ack delayed 20 cycles, dir=1 -> p_cs_b stays 1 during wait; data correct. Also: base=16'hFFFF, count=2 -> second byte written to 16'h0000.
- p_rst_b asserted during BUS_STROBE -> p_rd_b/p_wr_b/p_cs_b high immediately; busy=0; start after reset works normally.

Source files
------------

// File: rtl/tube_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// tube_pkg : shared types and constants for the Tube R3 DMA sequencer
// Rev 1.0
// ------------------------------------------------------------------
package tube_pkg;

  localparam logic [2:0] c_r3_addr = 3'b101;

  localparam logic c_dir_p2h = 1'b0;  // parasite memory -> Tube R3 (write R3)
  localparam logic c_dir_h2p = 1'b1;  // Tube R3 -> parasite memory (read R3)

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_ARM        = 4'd1,
    S_WAIT_NMI   = 4'd2,
    S_MEM_RD     = 4'd3,
    S_BUS_SETUP  = 4'd4,
    S_BUS_STROBE = 4'd5,
    S_BUS_HOLD   = 4'd6,
    S_MEM_WR     = 4'd7,
    S_NEXT       = 4'd8,
    S_GUARD      = 4'd9,
    S_FINISH     = 4'd10
  } dma_state_e;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_SETUP  = 2'd1,
    PH_STROBE = 2'd2,
    PH_HOLD   = 2'd3
  } pbus_phase_e;

endpackage
`default_nettype wire

// File: rtl/tube_pbus_cycle.sv
`default_nettype none
// ------------------------------------------------------------------
// tube_pbus_cycle : one parasite-side Tube access (setup/strobe/hold)
// Rev 1.0
// ------------------------------------------------------------------
module tube_pbus_cycle
  import tube_pkg::*;
#(
  parameter int STROBE_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic rd,
  output logic cs_b,
  output logic rd_b,
  output logic wr_b,
  output logic last_strobe,
  output logic done
);

  localparam int CW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;

  pbus_phase_e   phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cs_b_q, cs_b_d;
  logic          rd_b_q, rd_b_d;
  logic          wr_b_q, wr_b_d;

  assign last_strobe = (phase_q == PH_STROBE) && (cnt_q == CW'(STROBE_CYC - 1));
  assign done        = (phase_q == PH_HOLD);

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    case (phase_q)
      PH_IDLE: begin
        if (start) phase_d = PH_SETUP;
      end
      PH_SETUP: begin
        phase_d = PH_STROBE;
        cnt_d   = '0;
      end
      PH_STROBE: begin
        if (last_strobe) phase_d = PH_HOLD;
        else             cnt_d   = cnt_q + CW'(1);
      end
      PH_HOLD: begin
        phase_d = PH_IDLE;
      end
      default: phase_d = PH_IDLE;
    endcase
    // Strobes are decoded from the next phase so they leave a flop glitch-free
    cs_b_d = (phase_d == PH_IDLE);
    rd_b_d = !((phase_d == PH_STROBE) && rd);
    wr_b_d = !((phase_d == PH_STROBE) && !rd);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      cs_b_q  <= 1'b1;
      rd_b_q  <= 1'b1;
      wr_b_q  <= 1'b1;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      cs_b_q  <= cs_b_d;
      rd_b_q  <= rd_b_d;
      wr_b_q  <= wr_b_d;
    end
  end

  assign cs_b = cs_b_q;
  assign rd_b = rd_b_q;
  assign wr_b = wr_b_q;

endmodule
`default_nettype wire

// File: rtl/tube_r3_dma_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tube_r3_dma_ctrl : NMI-paced block mover between memory and Tube R3
// Rev 1.0
// ------------------------------------------------------------------
module tube_r3_dma_ctrl
  import tube_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int CNT_W       = 16,
  parameter int STROBE_CYC  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              p_clk,
  input  logic              p_rst_b,
  input  logic              start,
  input  logic              dir,
  input  logic              two_byte,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  byte_count,
  input  logic              abort,
  input  logic              p_nmi_b,
  output logic [2:0]        p_addr,
  output logic              p_cs_b,
  output logic              p_rd_b,
  output logic              p_wr_b,
  output logic [7:0]        p_data_out,
  output logic              p_data_oe,
  input  logic [7:0]        p_data_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  remaining
);

  localparam int GW = $clog2(SYNC_STAGES + 2);

  dma_state_e              state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic                    dir_q, dir_d;
  logic                    two_byte_q, two_byte_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [CNT_W-1:0]        rem_q, rem_d;
  logic [1:0]              burst_q, burst_d;
  logic [7:0]              data_q, data_d;
  logic [GW-1:0]           guard_q, guard_d;
  logic                    abort_pend_q, abort_pend_d;
  logic                    aborted_q, aborted_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic                    oe_q, oe_d;

  logic                    nmi;
  logic                    cyc_start;
  logic                    cyc_last;
  logic                    cyc_done;
  logic [CNT_W-1:0]        rem_dec;
  logic [1:0]              burst_dec;

  assign nmi       = !sync_q[SYNC_STAGES-1];
  assign rem_dec   = rem_q - CNT_W'(1);
  assign burst_dec = burst_q - 2'd1;

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    two_byte_d   = two_byte_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    burst_d      = burst_q;
    data_d       = data_q;
    guard_d      = guard_q;
    aborted_d    = aborted_q;
    sync_d       = sync_q;
    sync_d[0]    = p_nmi_b;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];

    // An abort seen mid-byte is remembered so the byte can finish cleanly
    abort_pend_d = abort_pend_q | (abort && (state_q != S_IDLE) && (state_q != S_FINISH));

    case (state_q)
      S_IDLE: begin
        abort_pend_d = 1'b0;
        if (start) begin
          dir_d      = dir;
          two_byte_d = two_byte;
          addr_d     = base_addr;
          rem_d      = byte_count;
          aborted_d  = 1'b0;
          state_d    = (byte_count == '0) ? S_FINISH : S_WAIT_NMI;
        end
      end
      S_ARM: state_d = S_WAIT_NMI;
      S_WAIT_NMI: begin
        if (abort_pend_d) begin
          aborted_d = 1'b1;
          state_d   = S_FINISH;
        end else if (nmi) begin
          burst_d = (two_byte_q && (rem_q >= CNT_W'(2))) ? 2'd2 : 2'd1;
          state_d = (dir_q == c_dir_h2p) ? S_BUS_SETUP : S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        if (mem_ack) begin
          data_d  = mem_rdata;
          state_d = S_BUS_SETUP;
        end
      end
      S_BUS_SETUP: state_d = S_BUS_STROBE;
      S_BUS_STROBE: begin
        if (cyc_last) begin
          if (dir_q == c_dir_h2p) data_d = p_data_in;
          state_d = S_BUS_HOLD;
        end
      end
      S_BUS_HOLD: begin
        if (cyc_done) state_d = (dir_q == c_dir_h2p) ? S_MEM_WR : S_NEXT;
      end
      S_MEM_WR: begin
        if (mem_ack) state_d = S_NEXT;
      end
      S_NEXT: begin
        addr_d  = addr_q + ADDR_W'(1);
        rem_d   = rem_dec;
        burst_d = burst_dec;
        if (rem_dec == '0) begin
          aborted_d = abort_pend_d;
          state_d   = S_FINISH;
        end else if (abort_pend_d) begin
          aborted_d = 1'b1;
          state_d   = S_FINISH;
        end else if (burst_dec != 2'd0) begin
          state_d = (dir_q == c_dir_h2p) ? S_BUS_SETUP : S_MEM_RD;
        end else begin
          guard_d = '0;
          state_d = S_GUARD;
        end
      end
      S_GUARD: begin
        // Lets the NMI that started this burst drain out of the synchroniser
        if (abort_pend_d) begin
          aborted_d = 1'b1;
          state_d   = S_FINISH;
        end else if (guard_q == GW'(SYNC_STAGES)) begin
          state_d = S_WAIT_NMI;
        end else begin
          guard_d = guard_q + GW'(1);
        end
      end
      S_FINISH: begin
        abort_pend_d = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d    = !((state_d == S_IDLE) || (state_d == S_FINISH));
    done_d    = (state_d == S_FINISH);
    mem_req_d = (state_d == S_MEM_RD) || (state_d == S_MEM_WR);
    mem_we_d  = (state_d == S_MEM_WR);
    oe_d      = ((state_d == S_BUS_SETUP) || (state_d == S_BUS_STROBE) ||
                 (state_d == S_BUS_HOLD)) && (dir_d == c_dir_p2h);
  end

  assign cyc_start = (state_d == S_BUS_SETUP);

  always_ff @(posedge p_clk or negedge p_rst_b) begin
    if (!p_rst_b) begin
      state_q      <= S_IDLE;
      sync_q       <= '1;
      dir_q        <= c_dir_p2h;
      two_byte_q   <= 1'b0;
      addr_q       <= '0;
      rem_q        <= '0;
      burst_q      <= 2'd0;
      data_q       <= 8'h00;
      guard_q      <= '0;
      abort_pend_q <= 1'b0;
      aborted_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      oe_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      dir_q        <= dir_d;
      two_byte_q   <= two_byte_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      burst_q      <= burst_d;
      data_q       <= data_d;
      guard_q      <= guard_d;
      abort_pend_q <= abort_pend_d;
      aborted_q    <= aborted_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      oe_q         <= oe_d;
    end
  end

  tube_pbus_cycle #(
    .STROBE_CYC (STROBE_CYC)
  ) u_pbus (
    .clk         (p_clk),
    .rst_n       (p_rst_b),
    .start       (cyc_start),
    .rd          (dir_q),
    .cs_b        (p_cs_b),
    .rd_b        (p_rd_b),
    .wr_b        (p_wr_b),
    .last_strobe (cyc_last),
    .done        (cyc_done)
  );

  assign p_addr     = c_r3_addr;
  assign p_data_out = data_q;
  assign p_data_oe  = oe_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign remaining  = rem_q;

endmodule
`default_nettype wire

// File: tb/tb_tube_r3_dma_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_tube_r3_dma_ctrl : scoreboard bench for the Tube R3 DMA sequencer
// Rev 1.0
// ------------------------------------------------------------------
module tb_tube_r3_dma_ctrl;

  localparam int ADDR_W      = 16;
  localparam int CNT_W       = 16;
  localparam int STROBE_CYC  = 2;
  localparam int SYNC_STAGES = 2;

  logic              p_clk = 1'b0;
  logic              p_rst_b = 1'b0;
  logic              start = 1'b0, dir = 1'b0, two_byte = 1'b0, abort = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  byte_count = '0;
  logic              p_nmi_b = 1'b1;
  logic [2:0]        p_addr;
  logic              p_cs_b, p_rd_b, p_wr_b, p_data_oe;
  logic [7:0]        p_data_out;
  logic [7:0]        p_data_in = 8'h00;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata = 8'h00;
  logic              mem_ack = 1'b0;
  logic              busy, done, aborted;
  logic [CNT_W-1:0]  remaining;

  always #5 p_clk = ~p_clk;

  tube_r3_dma_ctrl #(
    .ADDR_W(ADDR_W), .CNT_W(CNT_W), .STROBE_CYC(STROBE_CYC), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .p_clk(p_clk), .p_rst_b(p_rst_b), .start(start), .dir(dir), .two_byte(two_byte),
    .base_addr(base_addr), .byte_count(byte_count), .abort(abort), .p_nmi_b(p_nmi_b),
    .p_addr(p_addr), .p_cs_b(p_cs_b), .p_rd_b(p_rd_b), .p_wr_b(p_wr_b),
    .p_data_out(p_data_out), .p_data_oe(p_data_oe), .p_data_in(p_data_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .done(done),
    .aborted(aborted), .remaining(remaining)
  );

  int          n_checks = 0, n_fail = 0;
  logic [7:0]  mem [0:65535];
  logic [23:0] exp_mem_q[$];
  logic [7:0]  exp_tube_q[$];
  int          wr_stamp[$];
  int          mem_lat = 1;
  int          mem_wr_cnt = 0, rd_pulses = 0, wr_pulses = 0, done_cnt = 0;
  int          cs_low_cyc = 0, overlap_err = 0, cyc = 0;
  bit          skip_mon = 1'b0;
  logic        prev_rd = 1'b1, prev_wr = 1'b1;
  int          rd_w = 0, wr_w = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: observed %0h required %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge p_clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge p_clk);
    start = 1'b0;
  endtask

  // sel: 0 mem writes, 1 Tube write pulses, 2 done pulses
  task automatic wait_ge(input string tag, input int sel, input int target);
    int t = 0;
    int v;
    v = (sel == 0) ? mem_wr_cnt : (sel == 1) ? wr_pulses : done_cnt;
    while (v < target && t < 3000) begin
      @(negedge p_clk);
      t++;
      v = (sel == 0) ? mem_wr_cnt : (sel == 1) ? wr_pulses : done_cnt;
    end
    check(tag, v >= target, 1);
  endtask

  // sel: 0 p_cs_b, 1 p_rd_b, 2 p_wr_b
  task automatic wait_low(input string tag, input int sel);
    int t = 0;
    logic v;
    v = (sel == 0) ? p_cs_b : (sel == 1) ? p_rd_b : p_wr_b;
    while (v !== 1'b0 && t < 500) begin
      @(negedge p_clk);
      t++;
      v = (sel == 0) ? p_cs_b : (sel == 1) ? p_rd_b : p_wr_b;
    end
    check(tag, t < 500, 1);
  endtask

  // Memory model: fixed latency, one-cycle ack, write scoreboard on the write path
  initial begin
    logic [23:0] e;
    forever begin
      @(negedge p_clk);
      if (mem_req && p_rst_b) begin
        repeat (mem_lat) @(negedge p_clk);
        if (mem_we) begin
          if (exp_mem_q.size() == 0) begin
            check("mem_wr_unexpected", exp_mem_q.size(), 1);
          end else begin
            e = exp_mem_q.pop_front();
            check("mem_wr_addr_data", {8'h00, mem_addr, mem_wdata}, {8'h00, e});
          end
          mem[mem_addr] = mem_wdata;
          mem_wr_cnt++;
        end else begin
          mem_rdata = mem[mem_addr];
        end
        mem_ack = 1'b1;
        @(negedge p_clk);
        mem_ack = 1'b0;
      end
    end
  end

  // Tube bus monitor
  initial begin
    logic [7:0] eb;
    forever begin
      @(negedge p_clk);
      cyc++;
      if (!skip_mon) begin
        if (!p_cs_b) cs_low_cyc++;
        if (mem_req && !p_cs_b) overlap_err++;
        if (done) done_cnt++;
        if (!p_rd_b) rd_w++;
        if (!p_wr_b) wr_w++;
        if (!prev_rd && p_rd_b) begin
          check("rd_width", rd_w, STROBE_CYC);
          check("rd_hold_cs", p_cs_b, 0);
          rd_pulses++;
          rd_w = 0;
        end
        if (!prev_wr && p_wr_b) begin
          check("wr_width", wr_w, STROBE_CYC);
          check("wr_hold_oe", p_data_oe, 1);
          check("wr_hold_cs", p_cs_b, 0);
          if (exp_tube_q.size() == 0) begin
            check("wr_unexpected", exp_tube_q.size(), 1);
          end else begin
            eb = exp_tube_q.pop_front();
            check("wr_data", p_data_out, eb);
          end
          wr_stamp.push_back(cyc);
          wr_pulses++;
          wr_w = 0;
        end
      end else begin
        rd_w = 0;
        wr_w = 0;
      end
      prev_rd = p_rd_b;
      prev_wr = p_wr_b;
    end
  end

  task automatic run_h2p(input logic [15:0] base, input int n, input int lat, input logic [7:0] d0);
    int w0 = mem_wr_cnt;
    int dc = done_cnt;
    mem_lat    = lat;
    dir        = 1'b1;
    two_byte   = 1'b0;
    base_addr  = base;
    byte_count = CNT_W'(n);
    pulse_start();
    for (int i = 0; i < n; i++) begin
      logic [15:0] a;
      logic [7:0]  d;
      a = base + 16'(i);
      d = d0 + 8'(i);
      exp_mem_q.push_back({a, d});
      p_data_in = d;
      p_nmi_b   = 1'b0;
      wait_low("h2p_cs_timeout", 0);
      p_nmi_b = 1'b1;
      wait_ge("h2p_memwr_timeout", 0, w0 + i + 1);
    end
    wait_ge("h2p_done_timeout", 2, dc + 1);
    tick(2);
    check("h2p_done_once", done_cnt, dc + 1);
    check("h2p_remaining", remaining, 0);
    check("h2p_sb_empty", exp_mem_q.size(), 0);
  endtask

  initial begin
    int r0, w0, dc, c0, o0;
    tick(2);
    check("rst_cs_b", p_cs_b, 1);
    check("rst_rd_b", p_rd_b, 1);
    check("rst_wr_b", p_wr_b, 1);
    check("rst_addr", p_addr, 3'b101);
    check("rst_oe", p_data_oe, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_busy_done", {busy, done, aborted}, 0);
    check("rst_remaining", remaining, 0);
    p_rst_b = 1'b1;
    tick(2);

    // 1: host->parasite, 1-byte mode, three NMIs
    r0 = rd_pulses;
    run_h2p(16'h0400, 3, 1, 8'hA1);
    check("t1_rd_pulses", rd_pulses - r0, 3);
    check("t1_mem0402", mem[16'h0402], 8'hA3);

    // 2: parasite->host, 2-byte mode, NMI held low: bursts 2,2,1
    for (int i = 0; i < 5; i++) begin
      mem[16'h0200 + i] = 8'h30 + 8'(i);
      exp_tube_q.push_back(8'h30 + 8'(i));
    end
    wr_stamp.delete();
    r0 = rd_pulses; w0 = wr_pulses; dc = done_cnt;
    mem_lat = 1; dir = 1'b0; two_byte = 1'b1; base_addr = 16'h0200; byte_count = 16'd5;
    p_nmi_b = 1'b0;
    pulse_start();
    wait_ge("t2_done_timeout", 2, dc + 1);
    p_nmi_b = 1'b1;
    tick(4);
    check("t2_wr_pulses", wr_pulses - w0, 5);
    check("t2_rd_pulses", rd_pulses - r0, 0);
    check("t2_done_once", done_cnt, dc + 1);
    check("t2_remaining", remaining, 0);
    check("t2_sb_empty", exp_tube_q.size(), 0);
    if (wr_stamp.size() == 5) begin
      check("t2_guard_gap1", (wr_stamp[2] - wr_stamp[1]) - (wr_stamp[1] - wr_stamp[0]), SYNC_STAGES + 2);
      check("t2_guard_gap2", (wr_stamp[4] - wr_stamp[3]) - (wr_stamp[3] - wr_stamp[2]), SYNC_STAGES + 2);
    end else begin
      check("t2_stamp_count", wr_stamp.size(), 5);
    end

    // 3: zero-length transfer
    c0 = cs_low_cyc;
    dir = 1'b1; byte_count = 16'd0;
    pulse_start();
    check("t3_done", done, 1);
    check("t3_busy", busy, 0);
    @(negedge p_clk);
    check("t3_done_end", done, 0);
    check("t3_busy_end", busy, 0);
    tick(3);
    check("t3_no_cs", cs_low_cyc - c0, 0);

    // 4: abort during the strobe of byte 2 of 10
    exp_tube_q.delete();
    for (int i = 0; i < 10; i++) begin
      mem[16'h0300 + i] = 8'h50 + 8'(i);
      exp_tube_q.push_back(8'h50 + 8'(i));
    end
    w0 = wr_pulses; dc = done_cnt;
    dir = 1'b0; two_byte = 1'b0; base_addr = 16'h0300; byte_count = 16'd10;
    p_nmi_b = 1'b0;
    pulse_start();
    wait_ge("t4_first_wr_timeout", 1, w0 + 1);
    wait_low("t4_wr_low_timeout", 2);
    abort = 1'b1;
    @(negedge p_clk);
    abort = 1'b0;
    wait_ge("t4_done_timeout", 2, dc + 1);
    p_nmi_b = 1'b1;
    tick(3);
    check("t4_wr_pulses", wr_pulses - w0, 2);
    check("t4_remaining", remaining, 8);
    check("t4_aborted", aborted, 1);
    check("t4_done_once", done_cnt, dc + 1);
    check("t4_sb_left", exp_tube_q.size(), 8);
    exp_tube_q.delete();
    byte_count = 16'd0;
    pulse_start();
    check("t4_aborted_cleared", aborted, 0);
    tick(2);

    // 4b: abort while waiting for NMI
    r0 = rd_pulses; dc = done_cnt;
    dir = 1'b1; byte_count = 16'd4; base_addr = 16'h0600;
    pulse_start();
    tick(5);
    abort = 1'b1;
    @(negedge p_clk);
    abort = 1'b0;
    wait_ge("t4b_done_timeout", 2, dc + 1);
    tick(2);
    check("t4b_remaining", remaining, 4);
    check("t4b_aborted", aborted, 1);
    check("t4b_no_rd", rd_pulses - r0, 0);

    // 5: slow memory and address wrap
    o0 = overlap_err;
    run_h2p(16'hFFFF, 2, 20, 8'hC4);
    check("t5_no_cs_during_mem", overlap_err - o0, 0);
    check("t5_mem_ffff", mem[16'hFFFF], 8'hC4);
    check("t5_mem_0000", mem[16'h0000], 8'hC5);

    // 6: reset asserted mid-strobe
    dir = 1'b1; two_byte = 1'b0; byte_count = 16'd4; base_addr = 16'h0700;
    p_data_in = 8'h77;
    p_nmi_b = 1'b0;
    pulse_start();
    wait_low("t6_rd_low_timeout", 1);
    skip_mon = 1'b1;
    #2 p_rst_b = 1'b0;
    #1;
    check("t6_rd_b", p_rd_b, 1);
    check("t6_cs_b", p_cs_b, 1);
    check("t6_wr_b", p_wr_b, 1);
    check("t6_busy", busy, 0);
    @(negedge p_clk);
    p_rst_b = 1'b1;
    p_nmi_b = 1'b1;
    tick(3);
    exp_mem_q.delete();
    skip_mon = 1'b0;
    tick(1);
    run_h2p(16'h0500, 1, 2, 8'h3C);
    check("t6_mem_0500", mem[16'h0500], 8'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
